ci_initiator: RTL and testbench

- Bus-side initiator for the custom-instruction (CI) interface; drives ciStart/ciN/ciValueA/ciValueB toward CI responder modules such as the profiling CI.
- Collects ciDone/ciResult from the responder, measures response latency and flags timeouts.
- Lets a DMA engine, bus slave or test sequencer issue custom instructions without the CPU, one transaction at a time.
- Request and response sides use valid/ready handshakes.

---
 rtl/ci_pkg.sv | 15 +
 rtl/ci_initiator_if.sv | 39 +++
 rtl/ci_wait_counter.sv | 31 +++
 rtl/ci_initiator.sv | 130 +++++++++++++
 tb/tb_ci_initiator.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ci_pkg.sv
// Shared widths, state encoding and constants for the custom-instruction initiator.
package ci_pkg;

  localparam int CI_ID_WIDTH      = 8;
  localparam int CI_DATA_WIDTH    = 32;
  localparam int TIMEOUT_DISABLED = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } ci_state_e;

endpackage

// File: rtl/ci_initiator_if.sv
// Request, response and CI-side signal bundle between the initiator and its environment.
interface ci_initiator_if
  import ci_pkg::*;
#(
  parameter int LAT_WIDTH = 16
);

  logic                     reqValid;
  logic                     reqReady;
  logic [CI_ID_WIDTH-1:0]   reqCiN;
  logic [CI_DATA_WIDTH-1:0] reqValueA;
  logic [CI_DATA_WIDTH-1:0] reqValueB;

  logic                     rspValid;
  logic                     rspReady;
  logic [CI_DATA_WIDTH-1:0] rspResult;
  logic                     rspTimeout;
  logic [LAT_WIDTH-1:0]     rspLatency;

  logic                     ciStart;
  logic [CI_ID_WIDTH-1:0]   ciN;
  logic [CI_DATA_WIDTH-1:0] ciValueA;
  logic [CI_DATA_WIDTH-1:0] ciValueB;
  logic                     ciDone;
  logic [CI_DATA_WIDTH-1:0] ciResult;

  modport master (
    input  reqValid, reqCiN, reqValueA, reqValueB, rspReady, ciDone, ciResult,
    output reqReady, rspValid, rspResult, rspTimeout, rspLatency,
           ciStart, ciN, ciValueA, ciValueB
  );

  modport slave (
    output reqValid, reqCiN, reqValueA, reqValueB, rspReady, ciDone, ciResult,
    input  reqReady, rspValid, rspResult, rspTimeout, rspLatency,
           ciStart, ciN, ciValueA, ciValueB
  );

endinterface

// File: rtl/ci_wait_counter.sv
// Saturating up-counter shared by latency measurement and timeout detection.
module ci_wait_counter #(
  parameter int LAT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [LAT_WIDTH-1:0] terminal,
  output logic [LAT_WIDTH-1:0] count,
  output logic [LAT_WIDTH-1:0] count_inc,
  output logic                 at_terminal
);

  localparam logic [LAT_WIDTH-1:0] ONE = LAT_WIDTH'(1);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

  // Next value, pinned at all-ones so a very slow responder never wraps to a small latency.
  assign count_inc   = (count == '1) ? count : count + ONE;
  assign at_terminal = (count == terminal);

endmodule

// File: rtl/ci_initiator.sv
// Issues one custom instruction per request, then reports result, latency and timeout.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int LAT_WIDTH      = 16
) (
  input  logic           clock,
  input  logic           nReset,
  ci_initiator_if.master bus,
  output logic           busy
);

  localparam logic [LAT_WIDTH-1:0] TERMINAL   = LAT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != TIMEOUT_DISABLED);

  ci_state_e state, next_state;

  logic [CI_ID_WIDTH-1:0]   op_n;
  logic [CI_DATA_WIDTH-1:0] op_a, op_b;
  logic [CI_DATA_WIDTH-1:0] rsp_result;
  logic                     rsp_timeout;
  logic [LAT_WIDTH-1:0]     rsp_latency;

  logic [LAT_WIDTH-1:0] count, count_inc;
  logic                 at_terminal, cnt_clear, cnt_enable;
  logic                 load_ops, capture_done, capture_timeout;

  ci_wait_counter #(.LAT_WIDTH(LAT_WIDTH)) u_counter (
    .clock       (clock),
    .nReset      (nReset),
    .clear       (cnt_clear),
    .enable      (cnt_enable),
    .terminal    (TERMINAL),
    .count       (count),
    .count_inc   (count_inc),
    .at_terminal (at_terminal)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state      = state;
    cnt_clear       = 1'b0;
    cnt_enable      = 1'b0;
    load_ops        = 1'b0;
    capture_done    = 1'b0;
    capture_timeout = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (bus.reqValid) begin
          load_ops   = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ciDone) begin
          capture_done = 1'b1;
          next_state   = RESP;
        end else begin
          cnt_enable = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        cnt_enable = 1'b1;
        // A done arriving on the terminal cycle still counts as a real answer.
        if (bus.ciDone) begin
          capture_done = 1'b1;
          next_state   = RESP;
        end else if (TIMEOUT_EN && at_terminal) begin
          capture_timeout = 1'b1;
          next_state      = RESP;
        end
      end
      RESP: begin
        if (bus.rspReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      op_n <= '0;
      op_a <= '0;
      op_b <= '0;
    end else if (load_ops) begin
      op_n <= bus.reqCiN;
      op_a <= bus.reqValueA;
      op_b <= bus.reqValueB;
    end
  end

  // The counter is still 0 in ISSUE, so count_inc yields latency 1 for a same-cycle done.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      rsp_latency <= '0;
    end else if (capture_done) begin
      rsp_result  <= bus.ciResult;
      rsp_timeout <= 1'b0;
      rsp_latency <= count_inc;
    end else if (capture_timeout) begin
      rsp_result  <= '0;
      rsp_timeout <= 1'b1;
      rsp_latency <= count;
    end
  end

  logic drive_ops;
  assign drive_ops = (state == ISSUE) || (state == WAIT);

  assign bus.reqReady   = (state == IDLE);
  assign bus.rspValid   = (state == RESP);
  assign bus.rspResult  = rsp_result;
  assign bus.rspTimeout = rsp_timeout;
  assign bus.rspLatency = rsp_latency;
  assign bus.ciStart    = (state == ISSUE);
  assign bus.ciN        = drive_ops ? op_n : '0;
  assign bus.ciValueA   = drive_ops ? op_a : '0;
  assign bus.ciValueB   = drive_ops ? op_b : '0;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_ci_initiator.sv
// Self-checking bench: directed vector table, randomized transactions against a reference model.
module tb_ci_initiator;

  localparam int TMO   = 8;
  localparam int TMO4  = 4;
  localparam int LATW  = 16;
  localparam int NEVER = 1000000;

  logic clock = 1'b0;
  logic nReset;
  logic busy, busy4;
  int   checks = 0;
  int   errors = 0;

  ci_initiator_if #(.LAT_WIDTH(LATW)) bus ();
  ci_initiator_if #(.LAT_WIDTH(LATW)) bus4 ();

  ci_initiator #(.TIMEOUT_CYCLES(TMO), .LAT_WIDTH(LATW)) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus),
    .busy   (busy)
  );

  ci_initiator #(.TIMEOUT_CYCLES(TMO4), .LAT_WIDTH(LATW)) dut4 (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus4),
    .busy   (busy4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    logic [31:0] res;
    int          hold;
    logic [31:0] expRes;
    logic        expTo;
    int          expLat;
    int          expRspCycle;
  } vec_t;

  task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Responder answering on cycle `delay` after ciStart (0 = same cycle) versus the timeout rule.
  function automatic void refModel(input int delay, input logic [31:0] res, input int tmo,
                                   output logic [31:0] eRes, output logic eTo,
                                   output int eLat, output int eRspCycle);
    if (tmo == 0 || delay <= tmo) begin
      eRes      = res;
      eTo       = 1'b0;
      eLat      = (delay + 1 > 65535) ? 65535 : delay + 1;
      eRspCycle = delay + 1;
    end else begin
      eRes      = 32'h0;
      eTo       = 1'b1;
      eLat      = tmo;
      eRspCycle = tmo + 1;
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                               input int delay, input logic [31:0] res, input int hold,
                               input bit keepValid,
                               output logic [31:0] gotRes, output logic gotTo, output int gotLat,
                               output int rspCycle, output int starts);
    bit opsOk, holdOk;
    checkVal("req_ready_idle", 64'(bus.reqReady), 64'(1));
    bus.reqValid  = 1'b1;
    bus.reqCiN    = id;
    bus.reqValueA = a;
    bus.reqValueB = b;
    @(posedge clock); #1;
    bus.reqValid  = 1'b0;
    bus.reqCiN    = 8'($urandom);
    bus.reqValueA = $urandom;
    bus.reqValueB = $urandom;
    opsOk    = 1'b1;
    rspCycle = -1;
    starts   = 0;
    for (int k = 0; k <= TMO + 4; k++) begin
      if (bus.rspValid) begin
        rspCycle = k;
        break;
      end
      if (bus.ciStart) starts++;
      if (bus.ciN !== id || bus.ciValueA !== a || bus.ciValueB !== b || bus.reqReady !== 1'b0)
        opsOk = 1'b0;
      bus.ciDone   = (k == delay);
      bus.ciResult = (k == delay) ? res : $urandom;
      @(posedge clock); #1;
    end
    bus.ciDone = 1'b0;
    checkVal("rsp_within_bound", 64'(rspCycle >= 0), 64'(1));
    checkVal("ops_stable_in_flight", 64'(opsOk), 64'(1));
    checkVal("ops_zero_in_resp", 64'(bus.ciN == 0 && bus.ciValueA == 0 && bus.ciValueB == 0), 64'(1));
    gotRes = bus.rspResult;
    gotTo  = bus.rspTimeout;
    gotLat = int'(bus.rspLatency);
    holdOk = !bus.reqReady;
    if (keepValid) begin
      bus.reqValid  = 1'b1;
      bus.reqCiN    = 8'h5C;
      bus.reqValueA = 32'h1111_2222;
      bus.reqValueB = 32'h3333_4444;
    end
    for (int h = 0; h < hold; h++) begin
      bus.ciDone   = 1'($urandom_range(0, 1));
      bus.ciResult = $urandom;
      @(posedge clock); #1;
      if (!bus.rspValid || bus.reqReady || bus.ciStart || bus.rspResult !== gotRes ||
          bus.rspTimeout !== gotTo || int'(bus.rspLatency) != gotLat)
        holdOk = 1'b0;
    end
    bus.ciDone = 1'b0;
    checkVal("rsp_held_under_backpressure", 64'(holdOk), 64'(1));
    bus.rspReady = 1'b1;
    @(posedge clock); #1;
    bus.rspReady = 1'b0;
    checkVal("rsp_released", 64'(bus.rspValid), 64'(0));
    checkVal("idle_after_rsp", 64'(busy), 64'(0));
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] gotRes, input logic gotTo,
                             input int gotLat, input int rspCycle, input int starts,
                             input logic [31:0] eRes, input logic eTo, input int eLat, input int eCyc);
    checkVal({tag, "_result"}, 64'(gotRes), 64'(eRes));
    checkVal({tag, "_timeout"}, 64'(gotTo), 64'(eTo));
    checkVal({tag, "_latency"}, 64'(gotLat), 64'(eLat));
    checkVal({tag, "_rsp_cycle"}, 64'(rspCycle), 64'(eCyc));
    checkVal({tag, "_start_once"}, 64'(starts), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] gRes, eRes;
    logic        gTo, eTo;
    int          gLat, rCyc, nStart, eLat, eCyc, d;
    bit          quietOk;

    vecs[0] = '{8'h08, 32'h0, 32'h1, 0, 32'h0, 0, 32'h0, 1'b0, 1, 1};
    vecs[1] = '{8'h21, 32'h1234_5678, 32'h9ABC_DEF0, 4, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0, 5, 5};
    vecs[2] = '{8'h33, 32'hA5A5_A5A5, 32'h5A5A_5A5A, NEVER, 32'h1111_1111, 0, 32'h0, 1'b1, 8, 9};
    vecs[3] = '{8'h44, 32'h0000_00FF, 32'hFF00_0000, 8, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0, 9, 9};
    vecs[4] = '{8'h45, 32'h7, 32'h9, 7, 32'h0BAD_C0DE, 0, 32'h0BAD_C0DE, 1'b0, 8, 8};
    vecs[5] = '{8'hFF, 32'hFFFF_FFFF, 32'h0, 1, 32'h0000_0001, 3, 32'h0000_0001, 1'b0, 2, 2};

    nReset        = 1'b0;
    bus.reqValid  = 1'b0;  bus.reqCiN  = '0; bus.reqValueA  = '0; bus.reqValueB  = '0;
    bus.rspReady  = 1'b0;  bus.ciDone  = 1'b0; bus.ciResult = '0;
    bus4.reqValid = 1'b0;  bus4.reqCiN = '0; bus4.reqValueA = '0; bus4.reqValueB = '0;
    bus4.rspReady = 1'b0;  bus4.ciDone = 1'b0; bus4.ciResult = '0;

    #2;
    checkVal("reset_busy", 64'(busy), 64'(0));
    checkVal("reset_ci_start", 64'(bus.ciStart), 64'(0));
    checkVal("reset_rsp_valid", 64'(bus.rspValid), 64'(0));
    checkVal("reset_req_ready", 64'(bus.reqReady), 64'(1));
    checkVal("reset_rsp_fields", {bus.rspResult, 15'(bus.rspLatency), bus.rspTimeout}, 64'(0));
    checkVal("reset_ci_operands", 64'({bus.ciN, bus.ciValueA} | 40'(bus.ciValueB)), 64'(0));
    #10 nReset = 1'b1;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].delay, vecs[i].res, vecs[i].hold,
                    1'b0, gRes, gTo, gLat, rCyc, nStart);
      checkOutput($sformatf("vec%0d", i), gRes, gTo, gLat, rCyc, nStart,
                  vecs[i].expRes, vecs[i].expTo, vecs[i].expLat, vecs[i].expRspCycle);
    end

    // Backpressure with a new request already waiting; it may only be taken from IDLE.
    applyStimulus(8'h4B, 32'hAAAA_0001, 32'hBBBB_0002, 2, 32'h600D_CAFE, 10, 1'b1,
                  gRes, gTo, gLat, rCyc, nStart);
    checkOutput("bp", gRes, gTo, gLat, rCyc, nStart, 32'h600D_CAFE, 1'b0, 3, 3);
    checkVal("bp_req_ready_idle", 64'(bus.reqReady), 64'(1));
    bus.reqCiN = 8'h5D;
    @(posedge clock); #1;
    bus.reqValid = 1'b0;
    checkVal("bp_next_start", 64'(bus.ciStart), 64'(1));
    checkVal("bp_next_id", 64'(bus.ciN), 64'(8'h5D));
    bus.ciDone   = 1'b1;
    bus.ciResult = 32'h5D5D_5D5D;
    @(posedge clock); #1;
    bus.ciDone = 1'b0;
    checkVal("bp_next_rsp", {31'(0), bus.rspValid, bus.rspResult}, {31'(0), 1'b1, 32'h5D5D_5D5D});
    bus.rspReady = 1'b1;
    @(posedge clock); #1;
    bus.rspReady = 1'b0;

    for (int n = 0; n < 30; n++) begin
      d = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TMO + 3));
      gRes = $urandom;
      refModel(d, gRes, TMO, eRes, eTo, eLat, eCyc);
      applyStimulus(8'($urandom), $urandom, $urandom, d, gRes, int'($urandom_range(0, 3)), 1'b0,
                    gRes, gTo, gLat, rCyc, nStart);
      checkOutput($sformatf("rand%0d", n), gRes, gTo, gLat, rCyc, nStart, eRes, eTo, eLat, eCyc);
    end

    // Reset pulled while the instruction is still in ISSUE.
    bus.reqValid = 1'b1; bus.reqCiN = 8'h66;
    @(posedge clock); #1;
    bus.reqValid = 1'b0;
    checkVal("issue_start_before_reset", 64'(bus.ciStart), 64'(1));
    nReset = 1'b0; #2;
    checkVal("issue_reset_start_low", 64'(bus.ciStart), 64'(0));
    @(posedge clock); #1; nReset = 1'b1;

    // Reset pulled during WAIT; no response may follow.
    bus.reqValid = 1'b1; bus.reqCiN = 8'h67; bus.reqValueA = 32'h55;
    @(posedge clock); #1;
    bus.reqValid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkVal("wait_busy_before_reset", 64'(busy), 64'(1));
    nReset = 1'b0; #2;
    checkVal("wait_reset_busy", 64'(busy), 64'(0));
    checkVal("wait_reset_start", 64'(bus.ciStart), 64'(0));
    checkVal("wait_reset_rsp_valid", 64'(bus.rspValid), 64'(0));
    checkVal("wait_reset_ci_n", 64'(bus.ciN), 64'(0));
    @(posedge clock); #1; nReset = 1'b1;
    quietOk = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.ciDone = 1'($urandom_range(0, 1));
      bus.ciResult = $urandom;
      @(posedge clock); #1;
      if (bus.rspValid || busy || bus.ciStart) quietOk = 1'b0;
    end
    bus.ciDone = 1'b0;
    checkVal("no_rsp_after_reset", 64'(quietOk), 64'(1));
    refModel(2, 32'h0ACE_0ACE, TMO, eRes, eTo, eLat, eCyc);
    applyStimulus(8'h68, 32'h1, 32'h2, 2, 32'h0ACE_0ACE, 1, 1'b0, gRes, gTo, gLat, rCyc, nStart);
    checkOutput("post_reset", gRes, gTo, gLat, rCyc, nStart, eRes, eTo, eLat, eCyc);

    // Short-timeout instance: done exactly at the terminal count, then one cycle too late.
    for (int dd = TMO4; dd <= TMO4 + 1; dd++) begin
      refModel(dd, 32'h0123_4567, TMO4, eRes, eTo, eLat, eCyc);
      bus4.reqValid = 1'b1; bus4.reqCiN = 8'h77; bus4.reqValueA = 32'hA; bus4.reqValueB = 32'hB;
      @(posedge clock); #1;
      bus4.reqValid = 1'b0;
      rCyc = -1;
      for (int k = 0; k <= TMO4 + 4; k++) begin
        if (bus4.rspValid) begin
          rCyc = k;
          break;
        end
        bus4.ciDone   = (k == dd);
        bus4.ciResult = (k == dd) ? 32'h0123_4567 : $urandom;
        @(posedge clock); #1;
      end
      bus4.ciDone = 1'b0;
      checkVal($sformatf("t4_d%0d_rsp_cycle", dd), 64'(rCyc), 64'(eCyc));
      checkVal($sformatf("t4_d%0d_result", dd), 64'(bus4.rspResult), 64'(eRes));
      checkVal($sformatf("t4_d%0d_timeout", dd), 64'(bus4.rspTimeout), 64'(eTo));
      checkVal($sformatf("t4_d%0d_latency", dd), 64'(bus4.rspLatency), 64'(eLat));
      bus4.rspReady = 1'b1;
      @(posedge clock); #1;
      bus4.rspReady = 1'b0;
      checkVal($sformatf("t4_d%0d_idle", dd), 64'(busy4), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
